sdram_arbiter: RTL and testbench

- Owns the single SDRAM command/address/data bus.
- Grants it to one of four sources in turn: sdram_init, auto-refresh, write, read.
- Sits between those four sequencer blocks and the SDRAM pins (W989DxDB model in benches).
- Idle-cycle command is NOP.

---
 rtl/sdram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM command/address/data bus and hands it to one
// of four sequencers (init, auto-refresh, write, read). After initialisation
// it arbitrates with fixed priority refresh > write > read. There is always
// at least one NOP (ARBIT) cycle between consecutive grants.
module sdram_arbiter #(
  parameter int          ADDR_W  = 13,
  parameter int          BANK_W  = 2,
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              aref_en_r;
  logic              wr_en_r;
  logic              rd_en_r;
  logic [3:0]        cmd_s;
  logic [BANK_W-1:0] bank_s;
  logic [ADDR_W-1:0] addr_s;

  // State register; reset forces IDLE so the init sequencer owns the bus.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant flags registered from the next state so they rise and fall on the
  // same edge as the state change they belong to.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
    end else begin
      aref_en_r <= (state_s == ST_AREF);
      wr_en_r   <= (state_s == ST_WRITE);
      rd_en_r   <= (state_s == ST_READ);
    end
  end

  // Next-state logic: fixed-priority arbitration, owner releases with *_end.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_end) begin
          state_s = ST_ARBIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_s = ST_AREF;
        end else if (wr_req) begin
          state_s = ST_WRITE;
        end else if (rd_req) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_ARBIT;
        end
      end
      ST_AREF: begin
        if (aref_end) begin
          state_s = ST_ARBIT;
        end else begin
          state_s = ST_AREF;
        end
      end
      ST_WRITE: begin
        if (wr_end) begin
          state_s = ST_ARBIT;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (rd_end) begin
          state_s = ST_ARBIT;
        end else begin
          state_s = ST_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus mux: the owning source drives the pins with no added latency; NOP
  // while arbitrating or in an unexpected state.
  always_comb begin
    cmd_s  = CMD_NOP;
    bank_s = {BANK_W{1'b0}};
    addr_s = {ADDR_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        cmd_s  = init_cmd;
        bank_s = init_bank;
        addr_s = init_addr;
      end
      ST_ARBIT: begin
        cmd_s  = CMD_NOP;
        bank_s = {BANK_W{1'b0}};
        addr_s = {ADDR_W{1'b0}};
      end
      ST_AREF: begin
        cmd_s  = aref_cmd;
        bank_s = aref_bank;
        addr_s = aref_addr;
      end
      ST_WRITE: begin
        cmd_s  = wr_cmd;
        bank_s = wr_bank;
        addr_s = wr_addr;
      end
      ST_READ: begin
        cmd_s  = rd_cmd;
        bank_s = rd_bank;
        addr_s = rd_addr;
      end
      default: begin
        cmd_s  = CMD_NOP;
        bank_s = {BANK_W{1'b0}};
        addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign aref_en      = aref_en_r;
  assign wr_en        = wr_en_r;
  assign rd_en        = rd_en_r;
  assign sdram_cke    = 1'b1;
  assign sdram_cs_n   = cmd_s[3];
  assign sdram_ras_n  = cmd_s[2];
  assign sdram_cas_n  = cmd_s[1];
  assign sdram_we_n   = cmd_s[0];
  assign sdram_ba     = bank_s;
  assign sdram_addr   = addr_s;
  assign sdram_dq_out = wr_sdram_data;
  // DQ is only ever driven while the write sequencer owns the bus.
  assign sdram_dq_oe  = wr_sdram_en & (state_r == ST_WRITE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed test-plan scenarios plus
// randomized traffic, all checked against a behavioural bus-ownership model.
module tb_sdram_arbiter;

  localparam int         ADDR_W = 13;
  localparam int         BANK_W = 2;
  localparam int         DATA_W = 16;
  localparam logic [3:0] NOP    = 4'b0111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_end;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [BANK_W-1:0] init_bank, aref_bank, wr_bank, rd_bank;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic              aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              aref_en, wr_en, rd_en;
  logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BANK_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  int total = 0;
  int bad   = 0;

  // Reference model: has init completed, and who owns the bus (-1 = nobody).
  bit inited;
  int owner;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .arb_clk(clk), .arb_rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank(aref_bank), .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .wr_en(wr_en), .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says the pins should be.
  task automatic check_outputs(input string tag);
    logic [3:0]        ec;
    logic [BANK_W-1:0] eb;
    logic [ADDR_W-1:0] ea;
    if (!inited) begin
      ec = init_cmd; eb = init_bank; ea = init_addr;
    end else if (owner == 0) begin
      ec = aref_cmd; eb = aref_bank; ea = aref_addr;
    end else if (owner == 1) begin
      ec = wr_cmd; eb = wr_bank; ea = wr_addr;
    end else if (owner == 2) begin
      ec = rd_cmd; eb = rd_bank; ea = rd_addr;
    end else begin
      ec = NOP; eb = '0; ea = '0;
    end
    check_val({tag, ".cmd"}, {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, ec});
    check_val({tag, ".ba"}, {30'd0, sdram_ba}, {30'd0, eb});
    check_val({tag, ".addr"}, {19'd0, sdram_addr}, {19'd0, ea});
    check_val({tag, ".grants"}, {29'd0, aref_en, wr_en, rd_en},
              {29'd0, (owner == 0) && inited, (owner == 1) && inited, (owner == 2) && inited});
    check_val({tag, ".dq_oe"}, {31'd0, sdram_dq_oe}, {31'd0, wr_sdram_en && inited && owner == 1});
    check_val({tag, ".dq_out"}, {16'd0, sdram_dq_out}, {16'd0, wr_sdram_data});
    check_val({tag, ".cke"}, {31'd0, sdram_cke}, 32'd1);
  endtask

  // Ownership rules applied to the inputs seen at a rising edge.
  task automatic model_update();
    if (!rst_n) begin
      inited = 1'b0;
      owner  = -1;
    end else if (!inited) begin
      if (init_end) begin
        inited = 1'b1;
        owner  = -1;
      end
    end else if (owner == -1) begin
      if (aref_req)      owner = 0;
      else if (wr_req)   owner = 1;
      else if (rd_req)   owner = 2;
    end else if ((owner == 0 && aref_end) || (owner == 1 && wr_end) || (owner == 2 && rd_end)) begin
      owner = -1;
    end
  endtask

  // One clock: inputs already set (at negedge); check, clock, update model.
  task automatic cycle(input string tag);
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_buses();
    init_cmd = 4'($urandom); init_bank = BANK_W'($urandom); init_addr = ADDR_W'($urandom);
    aref_cmd = 4'($urandom); aref_bank = BANK_W'($urandom); aref_addr = ADDR_W'($urandom);
    wr_cmd   = 4'($urandom); wr_bank   = BANK_W'($urandom); wr_addr   = ADDR_W'($urandom);
    rd_cmd   = 4'($urandom); rd_bank   = BANK_W'($urandom); rd_addr   = ADDR_W'($urandom);
    wr_sdram_data = DATA_W'($urandom);
    wr_sdram_en   = 1'($urandom);
  endtask

  task automatic clear_ctl();
    aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
  endtask

  initial begin
    inited = 1'b0;
    owner  = -1;
    rst_n  = 1'b0;
    init_end = 1'b0;
    clear_ctl();
    rand_buses();
    wr_sdram_en = 1'b1;
    #12;
    check_outputs("reset");

    // Init phase: pins follow the init sequencer until init_end.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_buses();
      cycle("init");
    end
    init_end = 1'b1;
    cycle("init_end");
    check_val("arbit_after_init", {31'd0, sdram_cs_n}, {31'd0, NOP[3]});

    // Refresh and write together: refresh wins, write follows after one NOP.
    aref_req = 1'b1; wr_req = 1'b1;
    rand_buses();
    cycle("arb_aref_wr");
    aref_req = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_buses(); cycle("aref_hold"); end
    aref_end = 1'b1;
    cycle("aref_end");
    aref_end = 1'b0;
    cycle("nop_gap");
    // Now in WRITE: drive known data; a stray aref_end must be ignored.
    wr_req = 1'b0;
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
    cycle("write_a5");
    aref_end = 1'b1;
    cycle("stray_aref_end");
    aref_end = 1'b0;
    check_val("still_write", {31'd0, wr_en}, 32'd1);
    wr_end = 1'b1;
    cycle("wr_end");
    wr_end = 1'b0;

    // Read, with rd_end while rd_req is held again: one NOP then re-grant.
    rd_req = 1'b1;
    cycle("rd_arb");
    wr_sdram_en = 1'b1;
    cycle("read_stray_dq");
    rd_end = 1'b1;
    cycle("rd_end_req");
    rd_end = 1'b0;
    cycle("rd_nop");
    check_val("rd_regrant", {31'd0, rd_en}, 32'd1);
    rd_req = 1'b0;
    rd_end = 1'b1;
    cycle("rd_done");
    rd_end = 1'b0;

    // Random traffic: requests held until granted, ends mostly from owner.
    for (int n = 0; n < 3000; n++) begin
      rand_buses();
      init_end = 1'($urandom);
      if (!(aref_req && owner != 0)) aref_req = ($urandom_range(0, 9) < 2);
      if (!(wr_req && owner != 1))   wr_req   = ($urandom_range(0, 9) < 3);
      if (!(rd_req && owner != 2))   rd_req   = ($urandom_range(0, 9) < 3);
      aref_end = (owner == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      wr_end   = (owner == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      rd_end   = (owner == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    // Asynchronous reset in the middle of a write burst.
    clear_ctl();
    init_end = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 20 && owner != 1; i++) begin
      if (owner != -1) begin
        aref_end = (owner == 0); rd_end = (owner == 2);
      end else begin
        aref_end = 1'b0; rd_end = 1'b0;
      end
      cycle("to_write");
    end
    check_val("reached_write", {31'd0, owner == 1}, 32'd1);
    clear_ctl();
    wr_sdram_en = 1'b1;
    cycle("in_write");
    #2;
    rst_n = 1'b0;
    #1;
    inited = 1'b0;
    owner  = -1;
    check_outputs("async_rst");
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin rand_buses(); cycle("rst_hold"); end
    rst_n = 1'b1;
    init_end = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_buses(); wr_req = 1'b1; cycle("reinit_wait"); end
    init_end = 1'b1;
    cycle("reinit_end");
    cycle("after_reinit");
    cycle("after_reinit2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
